// File: rtl/bin_seg_display_if.sv
// Bundle of the display block's value input and its converted/segment outputs.
// master = value producer / observer, slave = the bin_seg_display block.
interface bin_seg_display_if;
  logic [7:0]  data_bin;
  logic [11:0] bcd;
  logic        busy;
  logic        conv_done;
  logic [6:0]  seg;
  logic [2:0]  sel;

  modport master (output data_bin, input bcd, busy, conv_done, seg, sel);
  modport slave  (input data_bin, output bcd, busy, conv_done, seg, sel);
endinterface

// File: rtl/bin_seg_display.sv
// 8-bit binary to 3-digit BCD (iterative double-dabble) with a multiplexed
// common-anode 7-segment driver. Optional macro: LEAD_ZERO_BLANK_EN.
module bin_seg_display #(
  parameter int SCAN_DIV = 50000,
  parameter int SCAN_W   = 16
) (
  input logic            clk,
  input logic            rst_n,
  bin_seg_display_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [1:0]        state;
  logic [7:0]        snap;
  logic [7:0]        bin_sr;
  logic [11:0]       bcd_sr;
  logic [11:0]       bcd_adj;
  logic [2:0]        bit_cnt;
  logic [11:0]       bcd_q;
  logic              busy_q;
  logic              done_q;

  logic [SCAN_W-1:0] scan_cnt;
  logic              scan_wrap;
  logic [1:0]        digit;
  logic [3:0]        nibble;
  logic              blank;
  logic [6:0]        seg_next;
  logic [2:0]        sel_next;
  logic [6:0]        seg_q;
  logic [2:0]        sel_q;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  // Add-3 correction applied to every nibble before each shift.
  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < 3; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      snap    <= '0;
      bin_sr  <= '0;
      bcd_sr  <= '0;
      bit_cnt <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.data_bin != snap) begin
            snap    <= bus.data_bin;
            bin_sr  <= bus.data_bin;
            bcd_sr  <= '0;
            bit_cnt <= '0;
            busy_q  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_sr, bin_sr} <= {bcd_adj[10:0], bin_sr, 1'b0};
          bit_cnt          <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= LOAD;
        end
        LOAD: begin
          bcd_q  <= bcd_sr;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Digit scan runs freely, independent of the converter.
  assign scan_wrap = (scan_cnt == SCAN_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      digit    <= 2'd0;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      if (scan_wrap) digit <= (digit == 2'd2) ? 2'd0 : digit + 2'd1;
    end
  end

  always_comb begin
    nibble   = bcd_q[3:0];
    sel_next = 3'b110;
    case (digit)
      2'd1: begin
        nibble   = bcd_q[7:4];
        sel_next = 3'b101;
      end
      2'd2: begin
        nibble   = bcd_q[11:8];
        sel_next = 3'b011;
      end
      default: ;
    endcase
`ifdef LEAD_ZERO_BLANK_EN
    blank = ((digit == 2'd2) && (bcd_q[11:8] == 4'd0)) ||
            ((digit == 2'd1) && (bcd_q[11:4] == 8'd0));
`else
    blank = 1'b0;
`endif
    seg_next = blank ? 7'b1111111 : seg_code(nibble);
  end

  // Registered pin drivers: follow the digit index and live bcd one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= 3'b110;
      seg_q <= 7'b1000000;
    end else begin
      sel_q <= sel_next;
      seg_q <= seg_next;
    end
  end

  assign bus.bcd       = bcd_q;
  assign bus.busy      = busy_q;
  assign bus.conv_done = done_q;
  assign bus.seg       = seg_q;
  assign bus.sel       = sel_q;

endmodule
